// File: rtl/seq_stream_pkg.sv
// Shared constants, state encoding and successor/membership lookup for the
// 0->2->5->8->11->14->0 sequence family.
package seq_stream_pkg;

  localparam logic [3:0] SEQ_V0 = 4'd0;
  localparam logic [3:0] SEQ_V1 = 4'd2;
  localparam logic [3:0] SEQ_V2 = 4'd5;
  localparam logic [3:0] SEQ_V3 = 4'd8;
  localparam logic [3:0] SEQ_V4 = 4'd11;
  localparam logic [3:0] SEQ_V5 = 4'd14;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {is_member, succ}; non-members map to {0, SEQ_V0}.
  function automatic logic [4:0] seq_lookup(input logic [3:0] v);
    case (v)
      SEQ_V0:  return {1'b1, SEQ_V1};
      SEQ_V1:  return {1'b1, SEQ_V2};
      SEQ_V2:  return {1'b1, SEQ_V3};
      SEQ_V3:  return {1'b1, SEQ_V4};
      SEQ_V4:  return {1'b1, SEQ_V5};
      SEQ_V5:  return {1'b1, SEQ_V0};
      default: return {1'b0, SEQ_V0};
    endcase
  endfunction

endpackage

// File: rtl/seq_stream_checker_lut.sv
// seq_succ_lut: combinational membership test and successor for a 4-bit value.
module seq_succ_lut
  import seq_stream_pkg::*;
(
  input  logic [3:0] i_value,
  output logic       o_is_member,
  output logic [3:0] o_succ
);

  assign {o_is_member, o_succ} = seq_lookup(i_value);

endmodule

// File: rtl/seq_stream_checker.sv
// Locks onto the upstream sequence counter and flags/counts errors and wraps.
// Optional first-error capture ports: define SEQ_STREAM_CHECKER_FIRST_ERR_EN.
module seq_stream_checker
  import seq_stream_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_value,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [3:0]       expected
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
  ,
  output logic [3:0]       first_err_val,
  output logic [3:0]       first_err_exp,
  output logic             first_err_vld
`endif
);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_prev, w_prev_nxt;
  logic [3:0]       r_run, w_run_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_wrap_count, w_wrap_count_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;

  logic             w_in_member;
  logic [3:0]       w_unused_in_succ;
  logic             w_unused_prev_member;
  logic [3:0]       w_prev_succ;
  logic [3:0]       w_run_inc;
  logic             w_is_hold;

  seq_succ_lut u_in_lut (
    .i_value     (in_value),
    .o_is_member (w_in_member),
    .o_succ      (w_unused_in_succ)
  );

  seq_succ_lut u_prev_lut (
    .i_value     (r_prev),
    .o_is_member (w_unused_prev_member),
    .o_succ      (w_prev_succ)
  );

  assign w_run_inc = r_run + 4'd1;
  assign w_is_hold = (in_value == r_prev);

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_run_nxt        = r_run;
    w_err_count_nxt  = r_err_count;
    w_wrap_count_nxt = r_wrap_count;
    w_err_pulse_nxt  = 1'b0;
    case (r_state)
      SEARCH: begin
        if (in_valid && w_in_member) begin
          w_prev_nxt  = in_value;
          w_run_nxt   = '0;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (in_valid && !w_is_hold) begin
          if (in_value == w_prev_succ) begin
            w_prev_nxt = in_value;
            if (w_run_inc == 4'(LOCK_THRESH)) begin
              w_run_nxt   = '0;
              w_state_nxt = LOCKED;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else if (w_in_member) begin
            w_prev_nxt = in_value;
            w_run_nxt  = '0;
          end else begin
            w_run_nxt   = '0;
            w_state_nxt = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (in_valid && !w_is_hold) begin
          if (in_value == w_prev_succ) begin
            w_prev_nxt = in_value;
            if (r_prev == SEQ_V5 && r_wrap_count != '1)
              w_wrap_count_nxt = r_wrap_count + CNT_W'(1);
          end else begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_count != '1)
              w_err_count_nxt = r_err_count + CNT_W'(1);
            w_run_nxt = '0;
            if (w_in_member) begin
              w_prev_nxt  = in_value;
              w_state_nxt = TRACK;
            end else begin
              w_state_nxt = SEARCH;
            end
          end
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_prev_nxt  = '0;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_prev       <= '0;
      r_run        <= '0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_run        <= w_run_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
    end
  end

  // locked/expected decode registered state only, so they stay glitch-free
  // and drop in the same cycle err_pulse rises.
  assign locked     = (r_state == LOCKED);
  assign expected   = (r_state == TRACK || r_state == LOCKED) ? w_prev_succ : '0;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
  logic [3:0] r_first_err_val;
  logic [3:0] r_first_err_exp;
  logic       r_first_err_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_err_val <= '0;
      r_first_err_exp <= '0;
      r_first_err_vld <= 1'b0;
    end else if (w_err_pulse_nxt && !r_first_err_vld) begin
      r_first_err_val <= in_value;
      r_first_err_exp <= w_prev_succ;
      r_first_err_vld <= 1'b1;
    end
  end

  assign first_err_val = r_first_err_val;
  assign first_err_exp = r_first_err_exp;
  assign first_err_vld = r_first_err_vld;
`endif

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed + random bench for seq_stream_checker; two instances (default and
// CNT_W=2/LOCK_THRESH=1) share stimulus and are compared to a rule-level model.
module tb_seq_stream_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_value;

  logic       locked, err_pulse;
  logic [7:0] err_count, wrap_count;
  logic [3:0] expected;
  logic       locked_s, err_pulse_s;
  logic [1:0] err_count_s, wrap_count_s;
  logic [3:0] expected_s;
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
  logic [3:0] fe_val, fe_exp, fe_val_s, fe_exp_s;
  logic       fe_vld, fe_vld_s;
`endif

  always #5 clk = ~clk;

  seq_stream_checker #(.LOCK_THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .expected(expected)
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
    , .first_err_val(fe_val), .first_err_exp(fe_exp), .first_err_vld(fe_vld)
`endif
  );

  seq_stream_checker #(.LOCK_THRESH(1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s),
    .wrap_count(wrap_count_s), .expected(expected_s)
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
    , .first_err_val(fe_val_s), .first_err_exp(fe_exp_s), .first_err_vld(fe_vld_s)
`endif
  );

  // Reference model: mode 0=searching, 1=tracking, 2=locked.
  typedef struct {
    int mode; int prev; int run; int err; int wrap; bit pulse;
    int fval; int fexp; bit fvld;
  } mdl_t;

  mdl_t m[2];
  int   thresh[2] = '{3, 1};
  int   maxc[2]   = '{255, 3};
  int   seqv[6]   = '{0, 2, 5, 8, 11, 14};

  int passed = 0;
  int total  = 0;
  int pulses_s = 0;

  function automatic int idx_of(int v);
    for (int i = 0; i < 6; i++) if (seqv[i] == v) return i;
    return -1;
  endfunction

  function automatic int succ_of(int v);
    return seqv[(idx_of(v) + 1) % 6];
  endfunction

  task automatic mreset(int k);
    m[k] = '{0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0};
  endtask

  task automatic mstep(int k, bit vld, int v);
    m[k].pulse = 1'b0;
    if (!vld) return;
    if (m[k].mode == 0) begin
      if (idx_of(v) >= 0) begin m[k].prev = v; m[k].run = 0; m[k].mode = 1; end
    end else if (v == m[k].prev) begin
      // hold: no effect
    end else if (m[k].mode == 1) begin
      if (v == succ_of(m[k].prev)) begin
        m[k].prev = v; m[k].run++;
        if (m[k].run == thresh[k]) begin m[k].mode = 2; m[k].run = 0; end
      end else if (idx_of(v) >= 0) begin
        m[k].prev = v; m[k].run = 0;
      end else m[k].mode = 0;
    end else begin
      if (v == succ_of(m[k].prev)) begin
        if (m[k].prev == 14 && v == 0 && m[k].wrap < maxc[k]) m[k].wrap++;
        m[k].prev = v;
      end else begin
        m[k].pulse = 1'b1;
        if (!m[k].fvld) begin m[k].fvld = 1'b1; m[k].fval = v; m[k].fexp = succ_of(m[k].prev); end
        if (m[k].err < maxc[k]) m[k].err++;
        if (idx_of(v) >= 0) begin m[k].mode = 1; m[k].prev = v; m[k].run = 0; end
        else m[k].mode = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int exp_e;
      exp_e = (m[k].mode == 0) ? 0 : succ_of(m[k].prev);
      if (k == 0) begin
        chk("locked", 32'(locked), 32'(m[0].mode == 2));
        chk("err_pulse", 32'(err_pulse), 32'(m[0].pulse));
        chk("err_count", 32'(err_count), 32'(m[0].err));
        chk("wrap_count", 32'(wrap_count), 32'(m[0].wrap));
        chk("expected", 32'(expected), 32'(exp_e));
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
        chk("first_err_vld", 32'(fe_vld), 32'(m[0].fvld));
        if (m[0].fvld) begin
          chk("first_err_val", 32'(fe_val), 32'(m[0].fval));
          chk("first_err_exp", 32'(fe_exp), 32'(m[0].fexp));
        end
`endif
      end else begin
        chk("s_locked", 32'(locked_s), 32'(m[1].mode == 2));
        chk("s_err_pulse", 32'(err_pulse_s), 32'(m[1].pulse));
        chk("s_err_count", 32'(err_count_s), 32'(m[1].err));
        chk("s_wrap_count", 32'(wrap_count_s), 32'(m[1].wrap));
        chk("s_expected", 32'(expected_s), 32'(exp_e));
`ifdef SEQ_STREAM_CHECKER_FIRST_ERR_EN
        chk("s_first_err_vld", 32'(fe_vld_s), 32'(m[1].fvld));
`endif
      end
    end
  endtask

  task automatic cyc(bit r, bit vld, int v);
    reset    = r;
    in_valid = vld;
    in_value = v[3:0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) mreset(k);
      else mstep(k, vld, v);
    end
    #1;
    if (err_pulse_s) pulses_s++;
    check_all();
  endtask

  task automatic send(int v);
    cyc(1'b0, 1'b1, v);
  endtask

  initial begin
    int lv;
    reset = 1'b1; in_valid = 1'b0; in_value = '0;
    mreset(0); mreset(1);

    // Lock and wrap
    cyc(1'b1, 1'b0, 0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_expected", 32'(expected), 32'd0);
    send(0); send(0); send(2); send(5);
    chk("no_lock_before_8", 32'(locked), 32'd0);
    send(8);
    chk("lock_after_8", 32'(locked), 32'd1);
    send(11); send(14); send(0);
    chk("wrap_once", 32'(wrap_count), 32'd1);
    chk("no_errors", 32'(err_count), 32'd0);

    // Non-member error while locked at 8
    send(2); send(5); send(8);
    send(9);
    chk("nm_pulse", 32'(err_pulse), 32'd1);
    chk("nm_count", 32'(err_count), 32'd1);
    chk("nm_unlocked", 32'(locked), 32'd0);
    chk("nm_expected", 32'(expected), 32'd0);
    cyc(1'b0, 1'b0, 0);
    chk("nm_pulse_one_cycle", 32'(err_pulse), 32'd0);

    // Member error and relock
    cyc(1'b1, 1'b0, 0);
    send(0); send(2); send(5); send(8);
    send(14);
    chk("me_count", 32'(err_count), 32'd1);
    chk("me_track_expected", 32'(expected), 32'd0);
    send(0); send(2);
    chk("me_not_yet", 32'(locked), 32'd0);
    send(5);
    chk("me_relock", 32'(locked), 32'd1);
    chk("me_expected", 32'(expected), 32'd8);

    // Valid gaps across a legal stream
    cyc(1'b0, 1'b0, 3);
    send(8); cyc(1'b0, 1'b0, 9); send(11); cyc(1'b0, 1'b0, 7);
    send(14); cyc(1'b0, 1'b0, 1); send(0); send(0); cyc(1'b0, 1'b0, 0);
    chk("gap_locked", 32'(locked), 32'd1);
    chk("gap_err_count", 32'(err_count), 32'd1);

    // Saturation on the narrow instance
    cyc(1'b1, 1'b0, 0);
    pulses_s = 0;
    for (int n = 0; n < 5; n++) begin
      send(0); send(2); send(9);
    end
    chk("sat_count", 32'(err_count_s), 32'd3);
    chk("sat_pulses", 32'(pulses_s), 32'd5);

    // Reset while locked
    send(0); send(2); send(5); send(8); send(11);
    chk("pre_reset_locked", 32'(locked), 32'd1);
    cyc(1'b1, 1'b1, 14);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);

    // Randomised legal-biased streams
    lv = 0;
    for (int n = 0; n < 800; n++) begin
      int  p, v;
      bit  vld, r;
      r   = ($urandom_range(0, 99) < 2);
      vld = ($urandom_range(0, 3) != 0);
      p   = $urandom_range(0, 9);
      if (p < 6)      v = (idx_of(lv) >= 0) ? succ_of(lv) : 0;
      else if (p < 7) v = lv;
      else            v = $urandom_range(0, 15);
      if (vld) lv = v;
      cyc(r, vld, v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
